// File: rtl/definitions_pkg.sv
// Shared fetch-stage types and constants.
package definitions_pkg;

  typedef logic [31:0] word_32ut;

  localparam int unsigned FETCH_XLEN = 32;
  localparam word_32ut    NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    word_32ut              instr;
    logic                  filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch queue: entries are allocated at grant, filled by responses
// and popped by decode; a flush frees every entry at once.
module fetch_fifo
  import definitions_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  alloc_i,
  input  logic [XLEN-1:0]       alloc_pc_i,
  input  logic                  fill_i,
  input  word_32ut              fill_instr_i,
  input  logic                  pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                  head_valid_o,
  output logic [XLEN-1:0]       head_pc_o,
  output word_32ut              head_instr_o
);

  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam int unsigned   CW       = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [XLEN-1:0]  pc_q [DEPTH];
  word_32ut         instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]    head_ptr_q, head_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [XLEN-1:0]  last_pc_q;
  word_32ut         last_instr_q;
  logic             head_valid_s;

  // The head is only presentable once its response has landed.
  assign head_valid_s = (count_q != CNT_ZERO) && filled_q[head_ptr_q];

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    if (flush_i) begin
      alloc_ptr_d = PTR_ZERO;
      fill_ptr_d  = PTR_ZERO;
      head_ptr_d  = PTR_ZERO;
      count_d     = CNT_ZERO;
    end else begin
      if (alloc_i) alloc_ptr_d = alloc_ptr_q + PTR_ONE;
      else         alloc_ptr_d = alloc_ptr_q;
      if (fill_i)  fill_ptr_d  = fill_ptr_q + PTR_ONE;
      else         fill_ptr_d  = fill_ptr_q;
      if (pop_i)   head_ptr_d  = head_ptr_q + PTR_ONE;
      else         head_ptr_d  = head_ptr_q;
      count_d = count_q + CW'(alloc_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_ptr_q <= PTR_ZERO;
      fill_ptr_q  <= PTR_ZERO;
      head_ptr_q  <= PTR_ZERO;
      count_q     <= CNT_ZERO;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
    end
  end

  // Allocation clears the filled flag, so a popped slot needs no clean-up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= RESET_PC;
        instr_q[i] <= NOP_INSTR;
      end
      filled_q <= {DEPTH{1'b0}};
    end else if (flush_i) begin
      filled_q <= {DEPTH{1'b0}};
    end else begin
      if (alloc_i) begin
        pc_q[alloc_ptr_q]     <= alloc_pc_i;
        filled_q[alloc_ptr_q] <= 1'b0;
      end
      if (fill_i) begin
        instr_q[fill_ptr_q]  <= fill_instr_i;
        filled_q[fill_ptr_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_pc_q    <= RESET_PC;
      last_instr_q <= NOP_INSTR;
    end else if (head_valid_s) begin
      last_pc_q    <= pc_q[head_ptr_q];
      last_instr_q <= instr_q[head_ptr_q];
    end else begin
      last_pc_q    <= last_pc_q;
      last_instr_q <= last_instr_q;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = head_valid_s;
  assign head_pc_o    = head_valid_s ? pc_q[head_ptr_q] : last_pc_q;
  assign head_instr_o = head_valid_s ? instr_q[head_ptr_q] : last_instr_q;

endmodule

// File: rtl/fetch_cp.sv
// Instruction-fetch stage: PC generation, imem req/gnt/rvalid handshake and
// redirect handling in front of the in-order fetch queue.
module fetch_cp
  import definitions_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  word_32ut        imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_fd_o,
  output word_32ut        instr_fd_o,
  output logic [XLEN-1:0] pc_fd_o,
  output logic [XLEN-1:0] pc_plus4_fd_o,
  input  logic            instr_ready_fd_i
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  // In-flight counters must cover stale responses left behind by back-to-back redirects.
  localparam int unsigned DW = $clog2(DEPTH) + 4;
  localparam logic [DW-1:0] DISC_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0] DISC_ONE  = DW'(1'b1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [DW-1:0]   inflight_q, inflight_d;
  logic [DW-1:0]   discard_q, discard_d;
  logic            en_q;
  logic [CW-1:0]   count_s;
  logic            full_s, req_s, grant_s, fill_s, pop_s, valid_s;

  assign full_s  = (count_s == CW'(DEPTH));
  assign req_s   = en_q && !redirect_i && !full_s;
  assign grant_s = req_s && imem_gnt_i;
  assign fill_s  = imem_rvalid_i && !redirect_i && (discard_q == DISC_ZERO);
  assign pop_s   = valid_s && instr_ready_fd_i && !redirect_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      inflight_d = inflight_q - DW'(imem_rvalid_i);
      discard_d  = inflight_q - DW'(imem_rvalid_i);
    end else begin
      if (grant_s) fetch_pc_d = fetch_pc_q + XLEN'(32'd4);
      else         fetch_pc_d = fetch_pc_q;
      inflight_d = inflight_q + DW'(grant_s) - DW'(imem_rvalid_i);
      if (imem_rvalid_i && (discard_q != DISC_ZERO)) discard_d = discard_q - DISC_ONE;
      else                                           discard_d = discard_q;
    end
  end

  // en_q holds requests off until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= DISC_ZERO;
      discard_q  <= DISC_ZERO;
      en_q       <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      en_q       <= 1'b1;
    end
  end

  fetch_fifo #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (redirect_i),
    .alloc_i      (grant_s),
    .alloc_pc_i   (fetch_pc_q),
    .fill_i       (fill_s),
    .fill_instr_i (imem_rdata_i),
    .pop_i        (pop_s),
    .count_o      (count_s),
    .head_valid_o (valid_s),
    .head_pc_o    (pc_fd_o),
    .head_instr_o (instr_fd_o)
  );

  assign imem_req_o       = req_s;
  assign imem_addr_o      = fetch_pc_q;
  assign instr_valid_fd_o = valid_s;
  assign pc_plus4_fd_o    = pc_fd_o + XLEN'(32'd4);

endmodule
